// File: rtl/io_uart_rx_pkg.sv
// io_uart_rx_pkg: shared constants for the UART receiver peripheral.
// Holds the register word offsets within the 16-byte I/O window, the STATUS/CTRL
// bit positions and the divisor clamp helper.
package io_uart_rx_pkg;

    // Word offsets (adr[3:2]) inside the peripheral window
    localparam logic [1:0] RegRxdata = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegDiv    = 2'd2;
    localparam logic [1:0] RegCtrl   = 2'd3;

    // STATUS write-one-to-clear bits
    localparam int unsigned StatOverrunBit  = 7;
    localparam int unsigned StatFrameErrBit = 8;

    // CTRL bits
    localparam int unsigned CtrlRxEnBit  = 0;
    localparam int unsigned CtrlIrqEnBit = 1;
    localparam int unsigned CtrlFlushBit = 2;

    // Smallest usable clocks-per-bit; the half-bit start delay must stay >= 2
    localparam logic [15:0] DivMin = 16'd4;

    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < DivMin) ? DivMin : div;
    endfunction

endpackage

// File: rtl/io_uart_rx_sync_fifo8.sv
// io_uart_rx_sync_fifo8: 16 x 8 synchronous FIFO for the UART receiver.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push_i, wdata_i    write request and byte (ignored while full)
//   pop_i              read request (ignored while empty)
//   flush_i            empties the FIFO; wins over a coincident push or pop
//   rdata_o            head byte, valid whenever empty_o is low (read-first)
//   count_o, full_o, empty_o   occupancy
module io_uart_rx_sync_fifo8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output logic [7:0] rdata_o,
    output logic [4:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [16];
    logic [3:0] wr_ptr_q, wr_ptr_d;
    logic [3:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full_o  = (count_q == 5'd16);
    assign empty_o = (count_q == 5'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 4'd0;
            rd_ptr_d = 4'd0;
            count_d  = 5'd0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 4'd1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 4'd1;
            count_d = count_q + {4'd0, do_push} - {4'd0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 4'd0;
            rd_ptr_q <= 4'd0;
            count_q  <= 5'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy tracking guards every read
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/io_uart_rx.sv
// io_uart_rx: memory-mapped 8N1 UART receiver with a 16-byte receive FIFO.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx2                        serial input, idle high, asynchronous
//   dma_io_we/wadr/wdata       bus write port (word addresses)
//   dma_io_radr/radr_en        bus read port; 1-cycle read latency
//   dma_io_rdata_in/rdata      read-data daisy chain in/out
//   rx_irq_1shot               one-cycle pulse per byte accepted while irq_en
//   rx_irq                     level: FIFO not empty and irq_en
// Registers: 0x0 RXDATA (pop), 0x4 STATUS, 0x8 DIV, 0xC CTRL.
module io_uart_rx
    import io_uart_rx_pkg::*;
#(
    parameter logic [15:0] IO_BASE     = 16'hFC40,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx2,
    input  logic        dma_io_we,
    input  logic [15:2] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [15:2] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic        rx_irq_1shot,
    output logic        rx_irq
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    // Synchroniser plus one extra stage for falling-edge detection
    logic rx_meta_q, rxs_q, rxs_prev_q;

    rx_state_e   state_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        push_q;
    logic [7:0]  push_byte_q;

    logic [15:0] div_q;
    logic        rx_en_q, irq_en_q;
    logic        overrun_q, frame_err_q;
    logic        rd_hit_q;
    logic [31:0] rdata_q, rdata_d;

    logic       wr_hit, rd_hit, flush, pop;
    logic [1:0] wr_reg, rd_reg;
    logic       timer_exp, rx_fall, stop_fail;
    logic [7:0] fifo_head;
    logic [4:0] fifo_count;
    logic       fifo_full, fifo_empty;

    logic unused_wdata;
    assign unused_wdata = ^dma_io_wdata[31:16];

    // Bus decode
    assign wr_hit = dma_io_we && (dma_io_wadr[15:4] == IO_BASE[15:4]);
    assign wr_reg = dma_io_wadr[3:2];
    assign rd_hit = dma_io_radr_en && (dma_io_radr[15:4] == IO_BASE[15:4]);
    assign rd_reg = dma_io_radr[3:2];
    assign flush  = wr_hit && (wr_reg == RegCtrl) && dma_io_wdata[CtrlFlushBit];
    assign pop    = rd_hit && (rd_reg == RegRxdata) && !fifo_empty;

    // Timer expiry: a load of L gives an expiry L cycles later
    assign timer_exp = (timer_q == 16'd1);
    assign rx_fall   = rxs_prev_q && !rxs_q;
    assign stop_fail = rx_en_q && (state_q == StStop) && timer_exp && !rxs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx2;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Receive FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            push_q      <= 1'b0;
            push_byte_q <= 8'd0;
        end else begin
            push_q <= 1'b0;
            if (!rx_en_q) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (rx_fall) begin
                            state_q <= StStart;
                            timer_q <= div_q >> 1;
                        end
                    end
                    StStart: begin
                        if (timer_exp) begin
                            if (rxs_q) begin
                                state_q <= StIdle;  // glitch, not a start bit
                            end else begin
                                state_q   <= StData;
                                timer_q   <= div_q;
                                bit_cnt_q <= 3'd0;
                            end
                        end else begin
                            timer_q <= timer_q - 16'd1;
                        end
                    end
                    StData: begin
                        if (timer_exp) begin
                            shift_q <= {rxs_q, shift_q[7:1]};
                            timer_q <= div_q;
                            if (bit_cnt_q == 3'd7) state_q <= StStop;
                            else                   bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else begin
                            timer_q <= timer_q - 16'd1;
                        end
                    end
                    StStop: begin
                        if (timer_exp) begin
                            state_q <= StIdle;
                            if (rxs_q) begin
                                push_q      <= 1'b1;
                                push_byte_q <= shift_q;
                            end
                        end else begin
                            timer_q <= timer_q - 16'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= DIV_DEFAULT;
            rx_en_q     <= 1'b0;
            irq_en_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (wr_hit && (wr_reg == RegDiv)) div_q <= clamp_div(dma_io_wdata[15:0]);
            if (wr_hit && (wr_reg == RegCtrl)) begin
                rx_en_q  <= dma_io_wdata[CtrlRxEnBit];
                irq_en_q <= dma_io_wdata[CtrlIrqEnBit];
            end
            // A new error event wins over a coincident clear
            if (push_q && fifo_full) begin
                overrun_q <= 1'b1;
            end else if (wr_hit && (wr_reg == RegStatus) && dma_io_wdata[StatOverrunBit]) begin
                overrun_q <= 1'b0;
            end
            if (stop_fail) begin
                frame_err_q <= 1'b1;
            end else if (wr_hit && (wr_reg == RegStatus) && dma_io_wdata[StatFrameErrBit]) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        case (rd_reg)
            RegRxdata: rdata_d = fifo_empty ? 32'd0 : {23'd0, 1'b1, fifo_head};
            RegStatus: rdata_d = {23'd0, frame_err_q, overrun_q, fifo_full, fifo_empty,
                                  fifo_count};
            RegDiv:    rdata_d = {16'd0, div_q};
            RegCtrl:   rdata_d = {30'd0, irq_en_q, rx_en_q};
            default:   rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rd_hit_q <= rd_hit;
            if (rd_hit) rdata_q <= rdata_d;
        end
    end

    io_uart_rx_sync_fifo8 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .wdata_i (push_byte_q),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign dma_io_rdata = rd_hit_q ? rdata_q : dma_io_rdata_in;
    assign rx_irq_1shot = push_q && !fifo_full && irq_en_q;
    assign rx_irq       = !fifo_empty && irq_en_q;

endmodule

// File: tb/tb_io_uart_rx.sv
// Bench for io_uart_rx: directed sequence with random bytes and divisors, checked
// against a queue-based model of the receive FIFO and sticky error flags.
module tb_io_uart_rx;

    localparam logic [15:0] ARxdata = 16'hFC40;
    localparam logic [15:0] AStatus = 16'hFC44;
    localparam logic [15:0] ADiv    = 16'hFC48;
    localparam logic [15:0] ACtrl   = 16'hFC4C;
    localparam logic [15:0] AOther  = 16'hFC80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx2;
    logic        dma_io_we;
    logic [15:2] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [15:2] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic        rx_irq_1shot;
    logic        rx_irq;

    io_uart_rx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx2             (rx2),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_radr_en  (dma_io_radr_en),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .rx_irq_1shot    (rx_irq_1shot),
        .rx_irq          (rx_irq)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_pulse = 0;
    int div_cur = 434;

    // Reference model: received bytes in order, sticky flags
    logic [7:0] model_q[$];
    bit         model_ovr = 1'b0;
    bit         model_ferr = 1'b0;

    always @(posedge clk) if (rx_irq_1shot === 1'b1) n_pulse++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_status();
        int n = model_q.size();
        return {23'd0, model_ferr, model_ovr, n == 16, n == 0, 5'(n)};
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (model_q.size() < 16) model_q.push_back(b);
        else model_ovr = 1'b1;
    endfunction

    // All bus tasks start and end at a negedge
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        dma_io_we = 1'b1;
        dma_io_wadr = addr[15:2];
        dma_io_wdata = data;
        @(negedge clk);
        dma_io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data);
        dma_io_radr_en = 1'b1;
        dma_io_radr = addr[15:2];
        @(negedge clk);
        data = dma_io_rdata;
        dma_io_radr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] addr,
                              input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic set_div(input int v);
        bus_write(ADiv, 32'(v));
        div_cur = v;
    endtask

    // Sends one 8N1 frame; optionally fires a CTRL flush in the push cycle
    task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                              input bit flush_at_push, output bit flushed);
        logic [8:0] bits;
        bits = {b, 1'b0};
        flushed = 1'b0;
        for (int i = 0; i < 9; i++) begin
            rx2 = bits[i];
            repeat (div_cur) @(negedge clk);
        end
        rx2 = stop_bit;
        for (int k = 0; k < div_cur + 6; k++) begin
            if (flush_at_push && !flushed && rx_irq_1shot === 1'b1) begin
                dma_io_we = 1'b1;
                dma_io_wadr = ACtrl[15:2];
                dma_io_wdata = 32'h7;
                flushed = 1'b1;
            end
            @(negedge clk);
            dma_io_we = 1'b0;
        end
        rx2 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit f;
        send_frame(b, 1'b1, 1'b0, f);
        model_push(b);
    endtask

    logic [31:0] rd;
    logic [7:0]  b;
    bit          fl;
    int          p0;
    int          n;

    initial begin
        rst_n = 1'b0;
        rx2 = 1'b1;
        dma_io_we = 1'b0;
        dma_io_wadr = '0;
        dma_io_wdata = '0;
        dma_io_radr = '0;
        dma_io_radr_en = 1'b0;
        dma_io_rdata_in = $urandom;
        repeat (3) @(negedge clk);
        check("rst_rdata_pass", dma_io_rdata, dma_io_rdata_in);
        check("rst_irq", {31'd0, rx_irq}, 32'd0);
        check("rst_1shot", {31'd0, rx_irq_1shot}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("rst_status", AStatus, 32'h20);
        read_check("rst_div", ADiv, 32'd434);
        read_check("rst_ctrl", ACtrl, 32'd0);

        // Basic frame
        set_div(8);
        bus_write(ACtrl, 32'h1);
        send_byte(8'hA5);
        read_check("a5_status", AStatus, exp_status());
        read_check("a5_rxdata", ARxdata, 32'h1A5);
        void'(model_q.pop_front());
        read_check("a5_status_after", AStatus, exp_status());
        read_check("empty_rxdata", ARxdata, 32'd0);

        // Divisor clamp
        bus_write(ADiv, 32'hFFFF_0002);
        read_check("div_clamp", ADiv, 32'd4);
        set_div($urandom_range(8, 16));
        read_check("div_readback", ADiv, 32'(div_cur));

        // Interrupts
        bus_write(ACtrl, 32'h3);
        p0 = n_pulse;
        b = 8'($urandom);
        send_byte(b);
        check("irq_pulses", 32'(n_pulse - p0), 32'd1);
        check("irq_level_high", {31'd0, rx_irq}, 32'd1);
        read_check("irq_rxdata", ARxdata, {23'd0, 1'b1, model_q.pop_front()});
        check("irq_level_low", {31'd0, rx_irq}, 32'd0);

        // Random bursts
        for (int r = 0; r < 3; r++) begin
            set_div($urandom_range(8, 16));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) send_byte(8'($urandom));
            read_check("burst_status", AStatus, exp_status());
            while (model_q.size() > 0)
                read_check("burst_rxdata", ARxdata, {23'd0, 1'b1, model_q.pop_front()});
            read_check("burst_empty", AStatus, exp_status());
        end

        // Overrun
        bus_write(ACtrl, 32'h1);
        for (int i = 0; i < 17; i++) send_byte(8'($urandom));
        read_check("ovr_status", AStatus, exp_status());
        for (int i = 0; i < 16; i++)
            read_check("ovr_rxdata", ARxdata, {23'd0, 1'b1, model_q.pop_front()});
        read_check("ovr_status_drained", AStatus, exp_status());
        bus_write(AStatus, 32'h80);
        model_ovr = 1'b0;
        read_check("ovr_cleared", AStatus, exp_status());

        // Framing error
        send_frame(8'h55, 1'b0, 1'b0, fl);
        model_ferr = 1'b1;
        read_check("ferr_status", AStatus, exp_status());
        bus_write(AStatus, 32'h100);
        model_ferr = 1'b0;
        read_check("ferr_cleared", AStatus, exp_status());

        // Start-bit glitch
        set_div(16);
        rx2 = 1'b0;
        repeat (2) @(negedge clk);
        rx2 = 1'b1;
        repeat (40) @(negedge clk);
        read_check("glitch_status", AStatus, exp_status());

        // Flush in the push cycle
        bus_write(ACtrl, 32'h3);
        send_byte(8'($urandom));
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b1, fl);
        check("flush_fired", {31'd0, fl}, 32'd1);
        model_q.delete();
        read_check("flush_status", AStatus, exp_status());
        read_check("flush_ctrl", ACtrl, 32'h3);

        // rx_en cleared mid-frame
        set_div(8);
        bus_write(ACtrl, 32'h1);
        rx2 = 1'b0;
        repeat (div_cur) @(negedge clk);
        rx2 = 1'b1;
        repeat (div_cur) @(negedge clk);
        rx2 = 1'b0;
        repeat (div_cur) @(negedge clk);
        bus_write(ACtrl, 32'h0);
        repeat (div_cur) @(negedge clk);
        rx2 = 1'b1;
        repeat (3 * div_cur) @(negedge clk);
        bus_write(ACtrl, 32'h1);
        send_byte(8'h81);
        read_check("abort_status", AStatus, exp_status());
        read_check("abort_rxdata", ARxdata, {23'd0, 1'b1, model_q.pop_front()});
        read_check("abort_empty", AStatus, exp_status());

        // Reads outside the window pass the chain through
        dma_io_radr_en = 1'b1;
        dma_io_radr = AOther[15:2];
        for (int i = 0; i < 3; i++) begin
            dma_io_rdata_in = $urandom;
            @(negedge clk);
            check("chain_pass", dma_io_rdata, dma_io_rdata_in);
        end
        dma_io_radr_en = 1'b0;
        dma_io_rdata_in = $urandom;
        @(negedge clk);
        check("chain_idle", dma_io_rdata, dma_io_rdata_in);

        // Reset mid-frame with a read in flight
        bus_write(ACtrl, 32'h3);
        send_byte(8'($urandom));
        check("pre_rst_irq", {31'd0, rx_irq}, 32'd1);
        rx2 = 1'b0;
        repeat (10) @(negedge clk);
        dma_io_rdata_in = $urandom;
        dma_io_radr_en = 1'b1;
        dma_io_radr = AStatus[15:2];
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        dma_io_radr_en = 1'b0;
        #1;
        check("mid_rst_rdata", dma_io_rdata, dma_io_rdata_in);
        check("mid_rst_irq", {31'd0, rx_irq}, 32'd0);
        check("mid_rst_1shot", {31'd0, rx_irq_1shot}, 32'd0);
        @(negedge clk);
        rx2 = 1'b1;
        rst_n = 1'b1;
        model_q.delete();
        div_cur = 434;
        @(negedge clk);
        read_check("post_rst_status", AStatus, exp_status());
        read_check("post_rst_div", ADiv, 32'd434);
        read_check("post_rst_ctrl", ACtrl, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
